// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Decoupled RV32 instruction-fetch front end. Owns the fetch
//               PC, issues in-order requests to a variable-latency
//               instruction memory, steers the next PC from the predictor
//               and buffers returned instructions in a DEPTH-entry queue
//               that drains into decode over a valid/ready handshake.
//               Optional macro FETCH_BYPASS_EN: a live response is
//               forwarded straight to decode when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic [XLEN-1:0]          bp_lookup_pc,
    input  logic                     bp_hit,
    input  logic                     bp_taken,
    input  logic [XLEN-1:0]          bp_target,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [XLEN-1:0]          imem_resp_data,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [XLEN-1:0]          dec_pc,
    output logic [XLEN-1:0]          dec_instr,
    output logic [XLEN-1:0]          dec_pred_target,
    output logic                     dec_pred_taken,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_SC_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_SP_W-1:0] c_SP_LAST = c_SP_W'(MAX_OUTSTANDING - 1);

    // One in-flight request: where it was fetched from and what we predicted.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] next_pc;
    } side_entry_t;

    // One buffered instruction waiting for decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            taken;
        logic [XLEN-1:0] target;
    } fq_entry_t;

    // State registers
    logic [XLEN-1:0]    fetch_pc_q,  fetch_pc_d;
    fq_entry_t          fq_mem_q   [DEPTH];
    fq_entry_t          fq_mem_d   [DEPTH];
    logic [c_PTR_W-1:0] fq_wr_q,     fq_wr_d;
    logic [c_PTR_W-1:0] fq_rd_q,     fq_rd_d;
    logic [c_CNT_W-1:0] fq_cnt_q,    fq_cnt_d;
    side_entry_t        side_mem_q [MAX_OUTSTANDING];
    side_entry_t        side_mem_d [MAX_OUTSTANDING];
    logic [c_SP_W-1:0]  side_wr_q,   side_wr_d;
    logic [c_SP_W-1:0]  side_rd_q,   side_rd_d;
    logic [c_SC_W-1:0]  side_cnt_q,  side_cnt_d;
    logic [MAX_OUTSTANDING-1:0] kill_q, kill_d;

    // Combinational control
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_pred_taken;
    logic [XLEN-1:0] w_next_pc;
    logic            w_side_empty;
    logic            w_resp_pop;
    logic            w_resp_keep;
    side_entry_t     w_side_head;
    fq_entry_t       w_resp_entry;
    fq_entry_t       w_dec_entry;
    logic            w_fq_empty;
    logic            w_bypass;
    logic            w_dec_valid;
    logic            w_enq;
    logic            w_deq;
    logic [3:0]      w_unused_lsbs;

    // Fetch addresses are always word aligned; the low bits are dropped.
    assign w_unused_lsbs = {redirect_pc[1:0], bp_target[1:0]};

    function automatic logic [c_SP_W-1:0] side_inc(input logic [c_SP_W-1:0] p);
        return (p == c_SP_LAST) ? '0 : p + 1'b1;
    endfunction

    // Request credit, response classification and decode-side selection.
    always_comb begin
        w_side_empty = (side_cnt_q == '0);
        w_fq_empty   = (fq_cnt_q == '0);
        // Credit counts queued plus in-flight so every response has a slot.
        w_req_valid  = reset && !redirect_valid
                    && (32'(side_cnt_q) < 32'(MAX_OUTSTANDING))
                    && ((32'(fq_cnt_q) + 32'(side_cnt_q)) < 32'(DEPTH));
        w_req_fire   = w_req_valid && imem_req_ready;
        w_pred_taken = bp_hit && bp_taken;
        w_next_pc    = w_pred_taken ? {bp_target[XLEN-1:2], 2'b00}
                                    : fetch_pc_q + XLEN'(4);
        // A response with no matching request (e.g. issued before reset) is ignored.
        w_resp_pop   = imem_resp_valid && !w_side_empty;
        w_side_head  = side_mem_q[side_rd_q];
        w_resp_keep  = w_resp_pop && !kill_q[side_rd_q] && !redirect_valid;
        w_resp_entry = '{pc:     w_side_head.pc,
                         instr:  imem_resp_data,
                         taken:  w_side_head.taken,
                         target: w_side_head.next_pc};
`ifdef FETCH_BYPASS_EN
        w_bypass     = w_fq_empty && w_resp_keep;
`else
        w_bypass     = 1'b0;
`endif
        w_dec_valid  = (!w_fq_empty || w_bypass) && !redirect_valid;
        w_dec_entry  = w_bypass ? w_resp_entry : fq_mem_q[fq_rd_q];
        w_deq        = !w_fq_empty && dec_ready && !redirect_valid;
        // A bypassed response that decode takes never lands in the queue.
        w_enq        = w_resp_keep && !(w_bypass && dec_ready);
    end

    // Next-state for fetch PC, in-flight tracker and instruction queue.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fq_mem_d   = fq_mem_q;
        fq_wr_d    = fq_wr_q;
        fq_rd_d    = fq_rd_q;
        fq_cnt_d   = fq_cnt_q;
        side_mem_d = side_mem_q;
        side_wr_d  = side_wr_q;
        side_rd_d  = side_rd_q;
        side_cnt_d = side_cnt_q;
        kill_d     = kill_q;

        if (w_req_fire) begin
            fetch_pc_d            = w_next_pc;
            side_mem_d[side_wr_q] = '{pc: fetch_pc_q, taken: w_pred_taken, next_pc: w_next_pc};
            kill_d[side_wr_q]     = 1'b0;
            side_wr_d             = side_inc(side_wr_q);
        end
        if (w_resp_pop) begin
            side_rd_d = side_inc(side_rd_q);
        end
        case ({w_req_fire, w_resp_pop})
            2'b10:   side_cnt_d = side_cnt_q + 1'b1;
            2'b01:   side_cnt_d = side_cnt_q - 1'b1;
            default: side_cnt_d = side_cnt_q;
        endcase

        if (w_enq) begin
            fq_mem_d[fq_wr_q] = w_resp_entry;
            fq_wr_d           = fq_wr_q + 1'b1;
        end
        if (w_deq) begin
            fq_rd_d = fq_rd_q + 1'b1;
        end
        case ({w_enq, w_deq})
            2'b10:   fq_cnt_d = fq_cnt_q + 1'b1;
            2'b01:   fq_cnt_d = fq_cnt_q - 1'b1;
            default: fq_cnt_d = fq_cnt_q;
        endcase

        // Redirect wins: flush the queue, poison everything still in flight.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            fq_wr_d    = '0;
            fq_rd_d    = '0;
            fq_cnt_d   = '0;
            kill_d     = '1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                fq_mem_q[i] <= '0;
            end
            fq_wr_q    <= '0;
            fq_rd_q    <= '0;
            fq_cnt_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                side_mem_q[i] <= '0;
            end
            side_wr_q  <= '0;
            side_rd_q  <= '0;
            side_cnt_q <= '0;
            kill_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fq_mem_q   <= fq_mem_d;
            fq_wr_q    <= fq_wr_d;
            fq_rd_q    <= fq_rd_d;
            fq_cnt_q   <= fq_cnt_d;
            side_mem_q <= side_mem_d;
            side_wr_q  <= side_wr_d;
            side_rd_q  <= side_rd_d;
            side_cnt_q <= side_cnt_d;
            kill_q     <= kill_d;
        end
    end

    assign bp_lookup_pc    = fetch_pc_q;
    assign imem_req_addr   = fetch_pc_q;
    assign imem_req_valid  = w_req_valid;
    assign dec_valid       = w_dec_valid;
    assign dec_pc          = w_dec_entry.pc;
    assign dec_instr       = w_dec_entry.instr;
    assign dec_pred_taken  = w_dec_entry.taken;
    assign dec_pred_target = w_dec_entry.target;
    assign fq_count        = fq_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a simple
//               fixed-latency in-order instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    // Cycle (after reset release) of the first decode slot with 1-cycle memory.
    localparam int FIRST = 2 - BYP;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] bp_lookup_pc;
    logic        bp_hit, bp_taken;
    logic [31:0] bp_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_instr, dec_pred_target;
    logic        dec_pred_taken;
    logic [2:0]  fq_count;

    int total = 0;
    int bad   = 0;
    int cyc;
    int lat;
    bit mem_en;
    bit force_resp;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bp_lookup_pc(bp_lookup_pc), .bp_hit(bp_hit), .bp_taken(bp_taken), .bp_target(bp_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_pred_target(dec_pred_target), .dec_pred_taken(dec_pred_taken), .fq_count(fq_count)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Memory drives this cycle's response, then combinational outputs settle.
    task automatic settle();
        if (force_resp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else if (mem_en && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(pend_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
    endtask

    // Memory records this cycle's handshakes.
    task automatic commit();
        if (imem_resp_valid && !force_resp) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
        end
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0; redirect_pc = '0;
        bp_hit = 1'b0; bp_taken = 1'b0; bp_target = '0;
        imem_req_ready = 1'b1; dec_ready = 1'b1; force_resp = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0; mem_en = 1'b1; lat = 1;
        pend_addr.delete(); pend_due.delete();
        imem_resp_valid = 1'b0; imem_resp_data = '0;
        tick(); tick();
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0; mem_en = 1'b0; lat = 1; cyc = 0;
        pend_addr.delete(); pend_due.delete();
        tick();
        settle();
        total++;
        if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0 || fq_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_ctrl got req_v=%b dec_v=%b cnt=%0d want 0 0 0", imem_req_valid, dec_valid, fq_count);
        end
        total++;
        if (dec_pc !== 32'h0 || dec_instr !== 32'h0 || dec_pred_target !== 32'h0 || dec_pred_taken !== 1'b0 || bp_lookup_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got pc=%h in=%h tg=%h tk=%b lk=%h want all 0", dec_pc, dec_instr, dec_pred_target, dec_pred_taken, bp_lookup_pc);
        end
        reset = 1'b1;
        settle();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_first_req got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] ep;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            settle();
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
                bad++;
                $display("FAIL seq_req k=%0d got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
            end
            if (k >= FIRST) begin
                ep = 32'(4 * (k - FIRST));
                total++;
                if (dec_valid !== 1'b1 || dec_pc !== ep || dec_instr !== instr_of(ep) ||
                    dec_pred_taken !== 1'b0 || dec_pred_target !== ep + 32'd4) begin
                    bad++;
                    $display("FAIL seq_dec k=%0d got v=%b pc=%h in=%h tk=%b tg=%h want pc=%h", k, dec_valid, dec_pc, dec_instr, dec_pred_taken, dec_pred_target, ep);
                end
            end else begin
                total++;
                if (dec_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL seq_dec_idle k=%0d got v=%b want 0", k, dec_valid);
                end
            end
            commit();
            tick();
        end
    endtask

    task automatic test_prediction();
        logic [31:0] exp_req [8] = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
        logic [31:0] exp_pc  [6] = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48};
        logic        exp_tk  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp_tg  [6] = '{32'h4, 32'h8, 32'h40, 32'h44, 32'h48, 32'h4C};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bp_hit = 1'b0; bp_taken = 1'b0; bp_target = '0;
            if (k == 2) begin bp_hit = 1'b1; bp_taken = 1'b1; bp_target = 32'h43; end
            if (k == 3) begin bp_hit = 1'b1; bp_taken = 1'b0; bp_target = 32'h80; end
            settle();
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_req[k] || bp_lookup_pc !== exp_req[k]) begin
                bad++;
                $display("FAIL pred_req k=%0d got v=%b a=%h lk=%h want %h", k, imem_req_valid, imem_req_addr, bp_lookup_pc, exp_req[k]);
            end
            if (k >= FIRST && (k - FIRST) < 6) begin
                total++;
                if (dec_valid !== 1'b1 || dec_pc !== exp_pc[k-FIRST] ||
                    dec_pred_taken !== exp_tk[k-FIRST] || dec_pred_target !== exp_tg[k-FIRST]) begin
                    bad++;
                    $display("FAIL pred_dec k=%0d got v=%b pc=%h tk=%b tg=%h want pc=%h tk=%b tg=%h", k, dec_valid, dec_pc, dec_pred_taken, dec_pred_target, exp_pc[k-FIRST], exp_tk[k-FIRST], exp_tg[k-FIRST]);
                end
            end
            commit();
            tick();
        end
        bp_hit = 1'b0; bp_taken = 1'b0; bp_target = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        dec_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            force_resp = (k == 7);
            settle();
            if (k >= 6) begin
                total++;
                if (fq_count !== 3'd4 || imem_req_valid !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
                    bad++;
                    $display("FAIL bp_full k=%0d got cnt=%0d req_v=%b dec_v=%b pc=%h want 4 0 1 0", k, fq_count, imem_req_valid, dec_valid, dec_pc);
                end
            end
            commit();
            tick();
        end
        force_resp = 1'b0;
        dec_ready  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            settle();
            total++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * j) || dec_instr !== instr_of(32'(4 * j))) begin
                bad++;
                $display("FAIL bp_drain j=%0d got v=%b pc=%h in=%h want pc=%h", j, dec_valid, dec_pc, dec_instr, 32'(4 * j));
            end
            commit();
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        bit seen;
        do_reset();
        lat = 3;
        for (int k = 0; k < 5; k++) begin
            redirect_valid = (k == 2);
            redirect_pc    = (k == 2) ? 32'h103 : 32'h0;
            settle();
            if (k == 2 || k == 3) begin
                total++;
                if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rdf_hold k=%0d got req_v=%b dec_v=%b want 0 0", k, imem_req_valid, dec_valid);
                end
            end
            if (k == 4) begin
                total++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || dec_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rdf_req got v=%b a=%h dec_v=%b want v=1 a=00000100 dec_v=0", imem_req_valid, imem_req_addr, dec_valid);
                end
            end
            commit();
            tick();
        end
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int k = 5; k < 15 && !seen; k++) begin
            settle();
            if (dec_valid === 1'b1) begin
                seen = 1'b1;
                total++;
                if (dec_pc !== 32'h100 || dec_instr !== instr_of(32'h100) || k != 8 - BYP) begin
                    bad++;
                    $display("FAIL rdf_first got pc=%h in=%h cyc=%0d want pc=00000100 in=%h cyc=%0d", dec_pc, dec_instr, k, instr_of(32'h100), 8 - BYP);
                end
            end
            commit();
            tick();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL rdf_timeout got no dec_valid want pc=00000100");
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        dec_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle(); commit(); tick();
        end
        force_resp = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2000;
        settle();
        total++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || fq_count !== 3'd4) begin
            bad++;
            $display("FAIL rfull_cycle got dec_v=%b req_v=%b cnt=%0d want 0 0 4", dec_valid, imem_req_valid, fq_count);
        end
        commit(); tick();
        force_resp = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
        settle();
        total++;
        if (fq_count !== 3'd0 || dec_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin
            bad++;
            $display("FAIL rfull_after got cnt=%0d dec_v=%b req_v=%b a=%h want 0 0 1 00002000", fq_count, dec_valid, imem_req_valid, imem_req_addr);
        end
        commit(); tick();
        for (int k = 0; k < 2; k++) begin
            settle();
            if (k == 1 - BYP) begin
                total++;
                if (dec_valid !== 1'b1 || dec_pc !== 32'h2000 || dec_instr !== instr_of(32'h2000)) begin
                    bad++;
                    $display("FAIL rfull_dec got v=%b pc=%h in=%h want v=1 pc=00002000", dec_valid, dec_pc, dec_instr);
                end
            end else begin
                total++;
                if (dec_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rfull_gap got v=%b want 0", dec_valid);
                end
            end
            commit(); tick();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_req [4] = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            redirect_valid = (k == 0);
            redirect_pc    = (k == 0) ? 32'hFFFF_FFFB : 32'h0;
            settle();
            if (k >= 1 && k <= 3) begin
                total++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_req[k]) begin
                    bad++;
                    $display("FAIL wrap_req k=%0d got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, exp_req[k]);
                end
            end
            if (k == 4 - BYP) begin
                total++;
                if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC || dec_pred_target !== 32'h0 || dec_pred_taken !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap_dec got v=%b pc=%h tg=%h tk=%b want pc=fffffffc tg=00000000 tk=0", dec_valid, dec_pc, dec_pred_target, dec_pred_taken);
                end
            end
            commit();
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] ep;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            settle(); commit(); tick();
        end
        reset = 1'b0; mem_en = 1'b0;
        settle();
        total++;
        if (fq_count !== 3'd0 || dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear got cnt=%0d dec_v=%b req_v=%b want 0 0 0", fq_count, dec_valid, imem_req_valid);
        end
        commit(); tick();
        reset = 1'b1; mem_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
                bad++;
                $display("FAIL midrst_req k=%0d got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
            end
            if (k >= FIRST) begin
                ep = 32'(4 * (k - FIRST));
                total++;
                if (dec_valid !== 1'b1 || dec_pc !== ep || dec_instr !== instr_of(ep)) begin
                    bad++;
                    $display("FAIL midrst_dec k=%0d got v=%b pc=%h in=%h want pc=%h in=%h", k, dec_valid, dec_pc, dec_instr, ep, instr_of(ep));
                end
            end
            commit(); tick();
        end
    endtask

    task automatic test_latency();
        logic exp_v;
        do_reset();
        settle(); commit(); tick();
        imem_req_ready = 1'b0;
        settle();
        exp_v = (BYP != 0);
        total++;
        if (dec_valid !== exp_v || fq_count !== 3'd0 || (exp_v && dec_instr !== 32'h0050_0093)) begin
            bad++;
            $display("FAIL lat_resp_cycle got v=%b in=%h cnt=%0d want v=%b cnt=0", dec_valid, dec_instr, fq_count, exp_v);
        end
        commit(); tick();
        settle();
        total++;
        if (dec_valid !== !exp_v || fq_count !== (exp_v ? 3'd0 : 3'd1) ||
            (!exp_v && (dec_instr !== 32'h0050_0093 || dec_pc !== 32'h0)) || imem_req_addr !== 32'h4) begin
            bad++;
            $display("FAIL lat_next_cycle got v=%b in=%h cnt=%0d a=%h want v=%b a=00000004", dec_valid, dec_instr, fq_count, imem_req_addr, !exp_v);
        end
        commit(); tick();
        imem_req_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_prediction();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_wrap();
        test_reset_midop();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
